// File: rtl/moore_seq_detect_param.sv
// ---------------------------------------------------------------------------
// moore_seq_detect_param
//
// Purpose:
//   Serial pattern detector built as a Moore machine. The state is the length
//   k (0..PATTERN_W) of the longest prefix of PATTERN that matches the most
//   recent input bits. The next-state table is the KMP automaton of PATTERN.
//   It is computed entirely at elaboration from the parameters, so there is
//   no runtime pattern load. The detect flag is decoded from the state alone.
//
// Parameters:
//   PATTERN_W  pattern length in bits (2..16)
//   PATTERN    target sequence, MSB is received first
//   OVERLAP    1 = overlapping detection, 0 = non-overlapping detection
//   CNT_W      match counter width (1..32)
//
// Ports:
//   clk        single clock, all state updates on its rising edge
//   rst        asynchronous, active-high reset
//   en         'in' carries a valid serial bit this cycle
//   in         serial data bit
//   out        Moore detect flag, high while k == PATTERN_W
//   progress   number of pattern bits currently matched (k)
//   match_cnt  saturating count of detections since reset
//
// Configuration macro:
//   MOORE_SEQ_MATCH_CNT_EN  when defined, the saturating match counter is
//                           built. When undefined, match_cnt is tied to zero
//                           and the port list does not change.
// ---------------------------------------------------------------------------
module moore_seq_detect_param #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101,
  parameter int                   OVERLAP   = 1,
  parameter int                   CNT_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           in,
  output logic                           out,
  output logic [$clog2(PATTERN_W+1)-1:0] progress,
  output logic [CNT_W-1:0]               match_cnt
);

  localparam int KW = $clog2(PATTERN_W + 1);

  // State encodings: the state value is the matched prefix length itself.
  localparam logic [KW-1:0] ST_IDLE = '0;
  localparam logic [KW-1:0] ST_FULL = KW'(PATTERN_W);

  // Bit i of the sequence in arrival order (i = 0 is the first bit received).
  function automatic int pat_bit(input int i);
    return int'(PATTERN[PATTERN_W-1-i]);
  endfunction

  // Next matched length from a partial match of length k (< PATTERN_W) when
  // bit b arrives. This is the longest pattern prefix that is a suffix of
  // (prefix_k, b). A matching bit therefore gives k+1, and a mismatching bit
  // falls back to the KMP failure value.
  function automatic int step(input int k, input int b);
    int  best;
    int  idx;
    int  sb;
    logic ok;
    best = 0;
    for (int j = 1; j <= PATTERN_W; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++) begin
          idx = k + 1 - j + t;
          sb  = (idx < k) ? pat_bit(idx) : b;
          if (sb != pat_bit(t)) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Failure value of the complete pattern: the longest proper prefix that is
  // also a suffix. An overlapping search resumes from this length.
  function automatic int full_fail();
    int   best;
    logic ok;
    best = 0;
    for (int j = 1; j < PATTERN_W; j++) begin
      ok = 1'b1;
      for (int t = 0; t < j; t++) begin
        if (pat_bit(PATTERN_W - j + t) != pat_bit(t)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  logic [KW-1:0] tbl0 [0:PATTERN_W];
  logic [KW-1:0] tbl1 [0:PATTERN_W];
  logic [KW-1:0] k;
  logic [KW-1:0] k_next;

  // Constant transition table, one row per state. The full-match row takes
  // the incoming bit as if it came from the restart state. The restart state
  // is the failure value when overlapping, and 0 otherwise.
  for (genvar s = 0; s <= PATTERN_W; s++) begin : g_tbl
    localparam int FROM = (s == PATTERN_W) ?
                          ((OVERLAP != 0) ? full_fail() : 0) : s;
    localparam int NXT0 = step(FROM, 0);
    localparam int NXT1 = step(FROM, 1);
    assign tbl0[s] = KW'(NXT0);
    assign tbl1[s] = KW'(NXT1);
  end

  // Next-state selection. The state holds while en is low. An unreachable
  // encoding above ST_FULL falls back to idle so the machine cannot lock up.
  always_comb begin
    k_next = k;
    if (k > ST_FULL) begin
      k_next = ST_IDLE;
    end else if (en) begin
      k_next = in ? tbl1[k] : tbl0[k];
    end
  end

  // State register. Reset discards any partial match immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= ST_IDLE;
    end else begin
      k <= k_next;
    end
  end

  // Moore outputs are decoded purely from the registered state.
  assign out      = (k == ST_FULL);
  assign progress = k;

`ifdef MOORE_SEQ_MATCH_CNT_EN
  logic             hit;
  logic [CNT_W-1:0] cnt;

  // A detection is an edge that lands in the full state. Sitting in the full
  // state with en low is a hold and does not count again.
  assign hit = (k_next == ST_FULL) && ((k != ST_FULL) || en);

  // Saturating counter: it stops at all-ones and never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (hit && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detect_param.sv
// ---------------------------------------------------------------------------
// tb_moore_seq_detect_param
//
// Purpose:
//   Self-checking bench for moore_seq_detect_param. Four instances share one
//   input stream:
//     d0  1101, overlapping, CNT_W=8
//     d1  1101, non-overlapping, CNT_W=8
//     d2  1101, overlapping, CNT_W=2 (counter saturation)
//     d3  1111, overlapping (all-equal pattern)
//   A history-based reference model tracks every instance. The model finds
//   the longest suffix of the received bits that equals a pattern prefix.
//   Directed scenarios also carry hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_moore_seq_detect_param;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic in  = 1'b0;

  always #5 clk = ~clk;

  logic       out_w  [N];
  logic [2:0] prog_w [N];
  logic [7:0] cnt0, cnt1, cnt3;
  logic [1:0] cnt2;
  int         cnt_w  [N];

  moore_seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8)) d0 (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out_w[0]), .progress(prog_w[0]), .match_cnt(cnt0));
  moore_seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8)) d1 (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out_w[1]), .progress(prog_w[1]), .match_cnt(cnt1));
  moore_seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(2)) d2 (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out_w[2]), .progress(prog_w[2]), .match_cnt(cnt2));
  moore_seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_W(8)) d3 (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out_w[3]), .progress(prog_w[3]), .match_cnt(cnt3));

  assign cnt_w[0] = int'(cnt0);
  assign cnt_w[1] = int'(cnt1);
  assign cnt_w[2] = int'(cnt2);
  assign cnt_w[3] = int'(cnt3);

`ifdef MOORE_SEQ_MATCH_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  int checks   = 0;
  int failures = 0;

  // Per-instance configuration of the reference model.
  int pw   [N] = '{4, 4, 4, 4};
  int patv [N] = '{13, 13, 13, 15};
  int ovl  [N] = '{1, 0, 1, 1};
  int cmax [N] = '{255, 255, 3, 255};

  // Model state: the recent bit history (newest bit in bit 0), the number of
  // valid history bits, the matched length and the detection count.
  logic [31:0] hist [N] = '{default: 32'd0};
  int          hl   [N] = '{default: 0};
  int          mk   [N] = '{default: 0};
  int          mc   [N] = '{default: 0};

  // The longest j <= w such that the last j bits received equal the first
  // j bits of the pattern.
  function automatic int model_k(input logic [31:0] h, input int len, input int w, input int p);
    int best;
    best = 0;
    for (int j = 1; j <= w; j++) begin
      if (j <= len) begin
        if (int'(h & ((32'd1 << j) - 32'd1)) == (p >> (w - j))) best = j;
      end
    end
    return best;
  endfunction

  // Reference model update. A non-overlapping detector discards its history
  // after a hit. An overlapping detector keeps it, trimmed to 16 bits.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        hist[i] = 32'd0;
        hl[i]   = 0;
        mk[i]   = 0;
        mc[i]   = 0;
      end
    end else if (en) begin
      for (int i = 0; i < N; i++) begin
        hist[i] = {hist[i][30:0], in};
        if (hl[i] < 16) hl[i] = hl[i] + 1;
        mk[i] = model_k(hist[i], hl[i], pw[i], patv[i]);
        if (mk[i] == pw[i]) begin
          if (mc[i] < cmax[i]) mc[i] = mc[i] + 1;
          if (ovl[i] == 0) hl[i] = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Per-cycle comparison of every instance against the model, 1 ns after
  // the active edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("cyc_out_d%0d", i), int'(out_w[i]), (mk[i] == pw[i]) ? 1 : 0);
      checkOutput($sformatf("cyc_prog_d%0d", i), int'(prog_w[i]), mk[i]);
      checkOutput($sformatf("cyc_cnt_d%0d", i), cnt_w[i], CNT_ON * mc[i]);
    end
  end

  // Drive inputs at the falling edge and return after the following rising
  // edge has been sampled and compared.
  task automatic applyStimulus(input logic e, input logic b);
    @(negedge clk);
    en = e;
    in = b;
    @(posedge clk);
    #2;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic s29 [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic s31 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  int   p31 [6] = '{1, 2, 2, 2, 3, 4};

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_out", int'(out_w[0]), 0);
    checkOutput("rst_prog", int'(prog_w[0]), 0);
    checkOutput("rst_cnt", cnt_w[0], 0);
    rst = 1'b0;

    // 1101101: overlapping vs non-overlapping.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, s29[i]);
      if (i == 3) begin
        checkOutput("ovl_out_bit4", int'(out_w[0]), 1);
        checkOutput("novl_out_bit4", int'(out_w[1]), 1);
      end
    end
    checkOutput("ovl_out_bit7", int'(out_w[0]), 1);
    checkOutput("novl_out_bit7", int'(out_w[1]), 0);
    checkOutput("novl_prog_bit7", int'(prog_w[1]), 1);
    checkOutput("ovl_cnt", cnt_w[0], CNT_ON * 2);
    checkOutput("novl_cnt", cnt_w[1], CNT_ON * 1);

    // 111101: failure fallback keeps progress at 2.
    resetDut();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, s31[i]);
      checkOutput($sformatf("fail_prog_%0d", i), int'(prog_w[0]), p31[i]);
      checkOutput($sformatf("fail_out_%0d", i), int'(out_w[0]), (i == 5) ? 1 : 0);
    end

    // 110, a three-cycle en=0 gap with in toggling, then 1.
    resetDut();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, i[0]);
      checkOutput($sformatf("gap_prog_%0d", i), int'(prog_w[0]), 3);
    end
    applyStimulus(1'b1, 1'b1);
    checkOutput("gap_out", int'(out_w[0]), 1);

    // 110, then a 7 ns reset pulse placed off the clock edge, then 1.
    resetDut();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_prog", int'(prog_w[0]), 0);
    checkOutput("arst_out", int'(out_w[0]), 0);
    #6 rst = 1'b0;
    applyStimulus(1'b1, 1'b1);
    checkOutput("arst_after_prog", int'(prog_w[0]), 1);
    checkOutput("arst_after_out", int'(out_w[0]), 0);

    // Five overlapping detections on the 2-bit counter instance.
    resetDut();
    for (int r = 0; r < 5; r++) begin
      if (r == 0) applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);
    end
    checkOutput("sat_cnt", cnt_w[2], CNT_ON * 3);
    checkOutput("sat_cnt_wide", cnt_w[0], CNT_ON * 5);

    // All-ones pattern: a detection on every bit after the first four.
    resetDut();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput($sformatf("ones_out_%0d", i), int'(out_w[3]), (i >= 3) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("ones_hold_out", int'(out_w[3]), 1);
    checkOutput("ones_cnt", cnt_w[3], CNT_ON * 3);

    // Random traffic with occasional resets, checked per cycle by the model.
    for (int c = 0; c < 400; c++) begin
      if ((c % 97) == 96) resetDut();
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/moore_seq_detect_param.md
MOORE_SEQ_DETECT_PARAM -- requirements
Module: moore_seq_detect_param

Interface
REQ-001 The block SHALL have parameter PATTERN_W, default 4, meaning pattern length in bits; legal range 2..16.
REQ-002 The block SHALL have parameter PATTERN, default 4'b1101, meaning the target sequence, MSB received first.
REQ-003 The block SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 The block SHALL have parameter CNT_W, default 8, meaning match counter width; legal range 1..32.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning asynchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit, meaning that in is a valid serial bit this cycle.
REQ-008 The block SHALL have port in, input, 1 bit, meaning the serial data bit.
REQ-009 The block SHALL have port out, output, 1 bit, meaning the Moore detect flag.
REQ-010 The block SHALL have port progress, output, clog2(PATTERN_W+1) bits, meaning the number of pattern bits currently matched.
REQ-011 The block SHALL have port match_cnt, output, CNT_W bits, meaning the number of detections since reset.

Function
REQ-012 The state register SHALL hold k = 0..PATTERN_W, where k is the length of the longest pattern prefix matched so far; progress SHALL equal k.
REQ-013 out SHALL be decoded only from state (Moore): out=1 iff k==PATTERN_W, with no combinational path from in or en.
REQ-014 When en=0 at a clock edge, the state SHALL hold, so out and progress hold.
REQ-015 When en=1 and k<PATTERN_W, bit b equal to PATTERN[PATTERN_W-1-k] SHALL give next k = k+1.
REQ-016 When en=1, k<PATTERN_W and the bit mismatches, next k SHALL be the longest proper pattern prefix that is a suffix of (matched prefix followed by b); this is the KMP failure rule and may be 0.
REQ-017 The failure/transition table SHALL be derived from PATTERN at elaboration; there SHALL be no runtime pattern load.
REQ-018 From k==PATTERN_W with en=1 and OVERLAP=1, b SHALL be applied as if from state f(PATTERN_W), the failure value of the full pattern.
REQ-019 From k==PATTERN_W with en=1 and OVERLAP=0, b SHALL be applied as if from state 0.
REQ-020 Latency: out SHALL be high in the cycle immediately after the edge that samples the last pattern bit; it stays high until the next en=1 edge.
REQ-021 match_cnt SHALL increment by 1 on each edge where next k==PATTERN_W and (k!=PATTERN_W or en=1).
REQ-022 match_cnt SHALL saturate at all-ones and never wrap.
REQ-023 A pattern of all-equal bits with OVERLAP=1 SHALL detect on every en=1 bit after the first PATTERN_W bits.

Reset
REQ-024 While rst=1, regardless of clk, the block SHALL hold k=0, out=0, progress=0 and match_cnt=0.
REQ-025 Reset asserted mid-sequence SHALL discard any partial match; matching SHALL restart from k=0 on the first en=1 edge after rst deasserts.
REQ-026 No output SHALL be X after reset.

Configuration
REQ-027 With macro MOORE_SEQ_MATCH_CNT_EN defined, match_cnt SHALL behave per REQ-021 and REQ-022.
REQ-028 With macro MOORE_SEQ_MATCH_CNT_EN undefined, the counter logic SHALL be absent and match_cnt SHALL be tied to 0, keeping the port list identical.

Verification
REQ-029 Scenario, defaults with OVERLAP=1 and en=1: in = 1,1,0,1,1,0,1 -> out high after bit 4 and after bit 7; match_cnt=2.
REQ-030 Scenario, same stream with OVERLAP=0 -> out high only after bit 4; match_cnt=1; progress=1 after bit 7.
REQ-031 Scenario, defaults: in = 1,1,1,1,0,1 -> progress 1,2,2,2,3,4; single detect after bit 6.
REQ-032 Scenario: 1,1,0 with en=1, then en=0 for 3 cycles with in toggling, then 1 with en=1 -> progress holds at 3 during the gap; detect after the final bit.
REQ-033 Scenario: 1,1,0 then rst pulsed for 7 ns off-edge, then 1 -> k=0 immediately on rst assertion; no detect; progress=1.
REQ-034 Scenario, CNT_W=2 with the macro defined: 5 detections -> match_cnt sticks at 3; with the macro undefined -> match_cnt=0 throughout.
